// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU slice: operation encodings, flag bit
// positions and the packed flags payload carried on the output bus.
// Optional feature macro used by this slice: ALU_SAT_EN (signed saturation of
// ADD/SUB results on overflow, handled in alu_core).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned FLAGS_W = 4;

   // Operation select encoding
   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR = 3'b110;
   localparam logic [OP_W-1:0] OP_SLT = 3'b111;

   // Bit positions inside the 4-bit flags word {negative, overflow, carry, zero}
   localparam int unsigned FLAG_ZERO     = 0;
   localparam int unsigned FLAG_CARRY    = 1;
   localparam int unsigned FLAG_OVERFLOW = 2;
   localparam int unsigned FLAG_NEGATIVE = 3;

   typedef struct packed {
      logic negative;
      logic overflow;
      logic carry;
      logic zero;
   } flags_t;

   // Assemble a flags word from its individual bits using the index constants
   function automatic flags_t pack_flags(input logic negative,
                                         input logic overflow,
                                         input logic carry,
                                         input logic zero);
      logic [FLAGS_W-1:0] vec;
      vec                = '0;
      vec[FLAG_NEGATIVE] = negative;
      vec[FLAG_OVERFLOW] = overflow;
      vec[FLAG_CARRY]    = carry;
      vec[FLAG_ZERO]     = zero;
      return flags_t'(vec);
   endfunction

endpackage

// File: rtl/pipelined_alu_if.sv
// -----------------------------------------------------------------------------
// pipelined_alu_if
// Valid/ready bus for the pipelined ALU: input side (operands + op) and output
// side (result, flags, completed-operation count).
//   master : environment view (drives inValid/operands/aluOp/outReady)
//   slave  : ALU view (drives inReady/outValid/result/flags/opCount)
// Parameters: WIDTH operand/result width, CNT_W opCount width.
// -----------------------------------------------------------------------------
interface pipelined_alu_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
);
   import alu_pkg::*;

   logic              inValid;
   logic              inReady;
   logic [WIDTH-1:0]  operandA;
   logic [WIDTH-1:0]  operandB;
   logic [OP_W-1:0]   aluOp;
   logic              outValid;
   logic              outReady;
   logic [WIDTH-1:0]  result;
   flags_t            flags;
   logic [CNT_W-1:0]  opCount;

   modport master (
      output inValid, operandA, operandB, aluOp, outReady,
      input  inReady, outValid, result, flags, opCount
   );

   modport slave (
      input  inValid, operandA, operandB, aluOp, outReady,
      output inReady, outValid, result, flags, opCount
   );

endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath between pipeline stage 1 and stage 2.
// Ports:
//   a, b  in  WIDTH  operands (b[$clog2(WIDTH)-1:0] is the shift amount)
//   op    in  3      operation select (alu_pkg OP_*)
//   res   out WIDTH  result
//   flg   out 4      {negative, overflow, carry, zero}
// Macro ALU_SAT_EN: when defined, ADD/SUB saturate to the signed range on
// overflow; when undefined they wrap and no saturation logic exists.
// -----------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] res,
   output flags_t           flg
);

   localparam int unsigned SH_W = $clog2(WIDTH);

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [SH_W-1:0]  shamt;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt;
   logic [WIDTH-1:0] raw;
   logic             carry;
   logic             ovf;

   // One extra bit captures ADD carry-out and SUB borrow (a < b unsigned)
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};
   assign shamt    = b[SH_W-1:0];
   assign slt      = ($signed(a) < $signed(b));

   // Signed overflow: operands agree (ADD) / differ (SUB) in sign and the
   // result sign departs from a's sign
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

   // Operation select
   always_comb begin
      raw   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            raw   = sum_ext[WIDTH-1:0];
            carry = sum_ext[WIDTH];
            ovf   = add_ovf;
         end
         OP_SUB: begin
            raw   = diff_ext[WIDTH-1:0];
            carry = diff_ext[WIDTH];
            ovf   = sub_ovf;
         end
         OP_AND:  raw = a & b;
         OP_OR:   raw = a | b;
         OP_XOR:  raw = a ^ b;
         OP_SHL:  raw = a << shamt;
         OP_SHR:  raw = a >> shamt;
         OP_SLT:  raw = WIDTH'(slt);
         default: raw = '0;
      endcase
   end

`ifdef ALU_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Overflow only occurs on ADD/SUB; a's sign tells which rail was crossed
   always_comb begin
      res = raw;
      if (ovf) begin
         res = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign res = raw;
`endif

   // Negative/zero always reflect the final (possibly saturated) result
   assign flg = pack_flags(res[WIDTH-1], ovf, carry, (res == '0));

endmodule

// File: rtl/pipelined_alu.sv
// -----------------------------------------------------------------------------
// pipelined_alu
// Two-stage valid/ready ALU: stage 1 registers operands/op, alu_core computes,
// stage 2 registers result/flags. One op per cycle with outReady high, latency
// two clocks from input transfer to outValid. Counts output transfers in a
// saturating counter.
// Ports:
//   clk  in  clock, all state on rising edge
//   rst  in  synchronous active-high reset, clears both stages and the counter
//   bus  pipelined_alu_if.slave (inValid/inReady/operandA/operandB/aluOp,
//        outValid/outReady/result/flags/opCount)
// Macro ALU_SAT_EN: see alu_core (signed saturation of ADD/SUB).
// -----------------------------------------------------------------------------
module pipelined_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   pipelined_alu_if.slave   bus
);

   // Stage 1 state
   logic             s1_full;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [OP_W-1:0]  s1_op;

   // Stage 2 state
   logic             s2_full;
   logic [WIDTH-1:0] s2_result;
   flags_t           s2_flags;

   logic [CNT_W-1:0] op_count;

   // Datapath between stages
   logic [WIDTH-1:0] core_res;
   flags_t           core_flg;

   // Handshake terms
   logic out_fire_c;
   logic s1_adv_c;
   logic in_ready_c;
   logic in_fire_c;

   // A stage advances when the stage below is empty or emptying this cycle
   assign out_fire_c = s2_full & bus.outReady;
   assign s1_adv_c   = s1_full & (~s2_full | out_fire_c);
   assign in_ready_c = ~s1_full | s1_adv_c;
   assign in_fire_c  = bus.inValid & in_ready_c;

   // Stage 1: capture operands on input transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_full <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_op   <= '0;
      end else begin
         if (in_fire_c) begin
            s1_full <= 1'b1;
            s1_a    <= bus.operandA;
            s1_b    <= bus.operandB;
            s1_op   <= bus.aluOp;
         end else if (s1_adv_c) begin
            s1_full <= 1'b0;
         end
      end
   end

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (s1_a),
      .b   (s1_b),
      .op  (s1_op),
      .res (core_res),
      .flg (core_flg)
   );

   // Stage 2: result/flags held stable until the consumer takes them
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_full   <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
      end else begin
         if (s1_adv_c) begin
            s2_full   <= 1'b1;
            s2_result <= core_res;
            s2_flags  <= core_flg;
         end else if (out_fire_c) begin
            s2_full <= 1'b0;
         end
      end
   end

   // Completed-operation counter, sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (out_fire_c && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

   assign bus.inReady  = in_ready_c;
   assign bus.outValid = s2_full;
   assign bus.result   = s2_result;
   assign bus.flags    = s2_flags;
   assign bus.opCount  = op_count;

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inValid  input  1  operandA/operandB/aluOp valid this cycle.
REQ-006 inReady  output  1  block accepts input this cycle.
REQ-007 operandA  input  WIDTH  first operand.
REQ-008 operandB  input  WIDTH  second operand / shift amount.
REQ-009 aluOp  input  3  operation select, encoding per REQ-014.
REQ-010 outValid  output  1  result/flags valid.
REQ-011 outReady  input  1  consumer accepts output this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  4  {negative, overflow, carry, zero}; opCount  output  CNT_W  completed operations.

Function
REQ-014 aluOp: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SLT (signed A<B gives 1, else 0).
REQ-015 Input transfer when inValid&&inReady; output transfer when outValid&&outReady.
REQ-016 Two-stage pipeline: stage 1 registers operands/op, stage 2 registers result/flags; latency exactly 2 cycles from input transfer to outValid with outReady held high.
REQ-017 Throughput one operation per cycle when outReady stays high.
REQ-018 A stage advances when the downstream stage is empty or transferring this cycle; inReady = !stage1Full || stage1Advance (combinational, no dependence on inValid).
REQ-019 Outputs held stable while outValid && !outReady; no operation dropped, duplicated or reordered.
REQ-020 ADD/SUB computed at WIDTH+1 bits; carry = ADD carry-out or SUB borrow (A<B unsigned); overflow = two's-complement signed overflow.
REQ-021 Shifts use operandB[$clog2(WIDTH)-1:0]; carry/overflow 0 for logic, shift, SLT ops.
REQ-022 zero = (result==0); negative = result[WIDTH-1]; both valid for all ops.
REQ-023 opCount increments by 1 on each output transfer; saturates at all-ones, no wrap.
REQ-024 Simultaneous input and output transfer in one cycle: both take effect, occupancy unchanged.

Reset
REQ-025 With rst high at a clock edge: both stages empty, outValid=0, result=0, flags=0, opCount=0.
REQ-026 inReady = 1 in the first cycle after rst deasserts.
REQ-027 rst mid-operation discards all in-flight operations; none appear after reset.

Configuration
REQ-028 Macro ALU_SAT_EN defined: ADD/SUB results saturate as signed values (max 2^(WIDTH-1)-1, min -2^(WIDTH-1)) whenever overflow=1; overflow flag still reports 1.
REQ-029 ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH; no saturation logic present.

Structure
REQ-030 Package alu_pkg holds the aluOp encoding constants, flag bit index constants and a flags struct typedef.
REQ-031 Combinational sub-module alu_core (operands, op -> result, flags) sits between stage 1 and stage 2; pipelined_alu holds the handshake, registers and counter.

Verification (WIDTH=8)
REQ-032 Reset: rst=1 for 2 cycles mid-stream -> outValid=0, result=0, flags=0, opCount=0, inReady=1 after release, no stale output.
REQ-033 SUB A=10, B=0 -> result=10, flags=0000, 2 cycles later; SUB A=5, B=5 -> result=0, zero=1; SUB A=3, B=5 -> result=254, carry=1, negative=1.
REQ-034 ADD A=127, B=1 -> overflow=1; without ALU_SAT_EN result=128, negative=1; with ALU_SAT_EN result=127, negative=0.
REQ-035 ADD A=200, B=100 -> carry=1, overflow=0, result=44; SHL A=0x81, B=9 -> shift 1, result=0x02; SLT A=0xFF, B=1 -> result=1.
REQ-036 Backpressure: outReady=0 for 5 cycles with inValid=1 -> exactly 2 ops accepted, inReady=0 afterwards; on release, outputs arrive in issue order, opCount=2 after the two output transfers complete.
REQ-037 Random: 5000 random operand/op sets with random outReady -> every output matches a bench reference model, and opCount equals the number of output transfers.
